alu_wb_queue: RTL and testbench

Result buffer between the integer ALU functional unit and the shared integer writeback port. The ALU produces one result per cycle, but the writeback port is arbitrated and may stall. This block decouples the two with a small circular buffer. It also squashes buffered results that a branch redirect makes stale, and presents surviving results to writeback in acceptance order.

---
 rtl/alu_wb_queue.sv | 176 +++++++++++++++++
 tb/tb_alu_wb_queue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_queue.sv
// alu_wb_queue: result buffer between the integer ALU and the shared integer writeback port.
//
// A DEPTH-slot circular buffer absorbs writeback stalls. Each slot carries the ALU payload
// plus a live bit; a branch redirect clears the live bit of every strictly younger entry,
// turning it into a bubble that is dropped at the head without ever asserting out_valid.
// Surviving results leave in acceptance order, at most one per cycle.
//
// Optional feature macro: ALU_WB_BYPASS_EN
//   When defined, an empty buffer with an unkilled in_valid and out_ready high forwards the
//   input straight to the outputs (zero latency) and writes nothing into the buffer.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid / in_ready   : ALU result handshake (in_ready = not full)
//   in_result/prd/robidx/need_to_wb : ALU payload
//   out_valid / out_ready : writeback handshake
//   out_result/prd/robidx/need_to_wb : head payload, zero when empty
//   flush_valid, flush_robidx : redirect; entries strictly younger than flush_robidx die
//   occupancy             : slots in use, bubbles included

module alu_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned ROB_W  = 7
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [PREG_W-1:0]        in_prd,
  input  logic [ROB_W-1:0]         in_robidx,
  input  logic                     in_need_to_wb,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [PREG_W-1:0]        out_prd,
  output logic [ROB_W-1:0]         out_robidx,
  output logic                     out_need_to_wb,

  input  logic                     flush_valid,
  input  logic [ROB_W-1:0]         flush_robidx,

  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  // MSB of a ROB index is a wrap flag: a differing flag inverts the plain index comparison.
  function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    return (a[ROB_W-1] ^ b[ROB_W-1]) ^ (a[ROB_W-2:0] > b[ROB_W-2:0]);
  endfunction

  // Pointer and live state (reset)
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [DEPTH-1:0] live_q, live_d;

  // Payload storage (no reset; only observed while its slot is occupied)
  logic [DEPTH-1:0][DATA_W-1:0] result_q, result_d;
  logic [DEPTH-1:0][PREG_W-1:0] prd_q, prd_d;
  logic [DEPTH-1:0][ROB_W-1:0]  robidx_q, robidx_d;
  logic [DEPTH-1:0]             nwb_q, nwb_d;

  logic [IdxW-1:0] head_idx, tail_idx;
  logic            empty, full;
  logic            head_live, head_kill, buf_valid;
  logic            in_kill, push_fire, bypass, write_en, pop;

  assign head_idx = head_q[IdxW-1:0];
  assign tail_idx = tail_q[IdxW-1:0];

  always_comb begin
    empty     = (head_q == tail_q);
    full      = (head_q[IdxW] != tail_q[IdxW]) && (head_idx == tail_idx);
    in_ready  = ~full;

    head_live = live_q[head_idx];
    // A flush withdraws out_valid in the same cycle, before the live bit is cleared.
    head_kill = flush_valid & younger(robidx_q[head_idx], flush_robidx);
    buf_valid = head_live & ~empty & ~head_kill;

    in_kill   = flush_valid & younger(in_robidx, flush_robidx);
    push_fire = in_valid & in_ready;

`ifdef ALU_WB_BYPASS_EN
    bypass    = empty & in_valid & ~in_kill & out_ready;
`else
    bypass    = 1'b0;
`endif

    // Killed pushes still take a slot so occupancy tracks them until they drain.
    write_en  = push_fire & ~bypass;
    // A bubble head leaves unconditionally; a live head leaves only on a handshake.
    pop       = ~empty & (~head_live | (buf_valid & out_ready));
  end

  // Outputs
  always_comb begin
    out_valid      = bypass | buf_valid;
    out_result     = '0;
    out_prd        = '0;
    out_robidx     = '0;
    out_need_to_wb = 1'b0;
    if (bypass) begin
      out_result     = in_result;
      out_prd        = in_prd;
      out_robidx     = in_robidx;
      out_need_to_wb = in_need_to_wb;
    end else if (!empty) begin
      out_result     = result_q[head_idx];
      out_prd        = prd_q[head_idx];
      out_robidx     = robidx_q[head_idx];
      out_need_to_wb = nwb_q[head_idx];
    end
  end

  // Pointer difference modulo 2*DEPTH gives 0..DEPTH directly.
  assign occupancy = tail_q - head_q;

  // Next state
  always_comb begin
    head_d   = head_q + PtrW'(pop);
    tail_d   = tail_q + PtrW'(write_en);
    live_d   = live_q;
    result_d = result_q;
    prd_d    = prd_q;
    robidx_d = robidx_q;
    nwb_d    = nwb_q;

    if (flush_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (younger(robidx_q[i], flush_robidx)) begin
          live_d[i] = 1'b0;
        end
      end
    end

    if (pop) begin
      live_d[head_idx] = 1'b0;
    end

    // The tail slot is never occupied when writing, so it cannot collide with the pop slot.
    if (write_en) begin
      live_d[tail_idx]   = ~in_kill;
      result_d[tail_idx] = in_result;
      prd_d[tail_idx]    = in_prd;
      robidx_d[tail_idx] = in_robidx;
      nwb_d[tail_idx]    = in_need_to_wb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      live_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      live_q <= live_d;
    end
  end

  always_ff @(posedge clock) begin
    result_q <= result_d;
    prd_q    <= prd_d;
    robidx_q <= robidx_d;
    nwb_q    <= nwb_d;
  end

endmodule

// File: tb/tb_alu_wb_queue.sv
module tb_alu_wb_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [5:0]  in_prd;
  logic [6:0]  in_robidx;
  logic        in_need_to_wb;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [5:0]  out_prd;
  logic [6:0]  out_robidx;
  logic        out_need_to_wb;
  logic        flush_valid;
  logic [6:0]  flush_robidx;
  logic [2:0]  occupancy;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  prd;
    logic [6:0]  rob;
    logic        nwb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  alu_wb_queue dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_result      (in_result),
    .in_prd         (in_prd),
    .in_robidx      (in_robidx),
    .in_need_to_wb  (in_need_to_wb),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_prd        (out_prd),
    .out_robidx     (out_robidx),
    .out_need_to_wb (out_need_to_wb),
    .flush_valid    (flush_valid),
    .flush_robidx   (flush_robidx),
    .occupancy      (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want test completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drive one ALU result; optionally record it as an expected writeback.
  task automatic drive_push(input logic [6:0] rob, input bit expect_out);
    exp_t e;
    in_valid      = 1'b1;
    in_robidx     = rob;
    in_result     = {$urandom, $urandom};
    in_prd        = 6'($urandom);
    in_need_to_wb = rob[0];
    e.res = in_result;
    e.prd = in_prd;
    e.rob = rob;
    e.nwb = in_need_to_wb;
    if (expect_out) exp_q.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    total++;
    if (out_result !== 64'd0 || out_prd !== 6'd0 || out_robidx !== 7'd0 || out_need_to_wb !== 1'b0) begin
      bad++;
      $display("FAIL reset_payload: got res=%0h prd=%0h rob=%0h nwb=%0b want all 0",
               out_result, out_prd, out_robidx, out_need_to_wb);
    end
    tick();
  endtask

  task automatic test_fill_drain;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(7'(i), 1'b1);
      tick();
    end
    // Push attempt while full must be refused.
    drive_push(7'd99, 1'b0);
    #3;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %0b want 0", in_ready); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occupancy: got %0d want 4", occupancy); end
    tick();
    #3;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_push_ignored: got occ %0d want 4", occupancy); end
    // Pop on a full buffer with in_valid still high: no push happens.
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) in_valid = 1'b0;
      #3;
      if (c == 0) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_in_ready: got %0b want 0", in_ready); end
      end
      total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL drain_valid[%0d]: got %0b want 1 (pending %0d)", c, out_valid, exp_q.size());
      end else begin
        exp_t e = exp_q.pop_front();
        if (out_robidx !== e.rob || out_result !== e.res || out_prd !== e.prd ||
            out_need_to_wb !== e.nwb) begin
          bad++;
          $display("FAIL drain_payload[%0d]: got rob=%0d res=%0h prd=%0d want rob=%0d res=%0h prd=%0d",
                   c, out_robidx, out_result, out_prd, e.rob, e.res, e.prd);
        end
      end
      tick();
    end
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid: got %0b want 0", out_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL drain_empty_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  task automatic test_flush_mid;
    int outs = 0;
    out_ready = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      drive_push(7'(i), i <= 6);
      tick();
    end
    in_valid     = 1'b0;
    flush_valid  = 1'b1;
    flush_robidx = 7'd6;
    #3;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_head_survives: got %0b want 1", out_valid); end
    tick();
    flush_valid = 1'b0;
    #3;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL flush_occ_bubbles: got %0d want 4", occupancy); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (out_valid === 1'b1) begin
        outs++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL flush_extra_output: got rob=%0d want none", out_robidx);
        end else begin
          exp_t e = exp_q.pop_front();
          if (out_robidx !== e.rob || out_result !== e.res) begin
            bad++;
            $display("FAIL flush_payload: got rob=%0d res=%0h want rob=%0d res=%0h",
                     out_robidx, out_result, e.rob, e.res);
          end
        end
      end
      tick();
    end
    #3;
    total++; if (outs != 2) begin bad++; $display("FAIL flush_out_count: got %0d want 2", outs); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_drain_occ: got %0d want 0", occupancy); end
    tick();
  endtask

  task automatic test_wrap_age;
    out_ready = 1'b0;
    drive_push(7'h7F, 1'b0);
    tick();
    in_valid     = 1'b0;
    flush_valid  = 1'b1;
    flush_robidx = 7'h02;
    #3;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_older_comb: got %0b want 1", out_valid); end
    tick();
    flush_valid = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b1 || out_robidx !== 7'h7F) begin
      bad++;
      $display("FAIL wrap_older_kept: got valid=%0b rob=%0h want valid=1 rob=7f", out_valid, out_robidx);
    end
    flush_valid  = 1'b1;
    flush_robidx = 7'h7E;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_younger_comb: got %0b want 0", out_valid); end
    tick();
    flush_valid = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_killed_valid: got %0b want 0", out_valid); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL wrap_bubble_occ: got %0d want 1", occupancy); end
    tick();
    #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL wrap_bubble_drop: got %0d want 0", occupancy); end
    tick();
  endtask

  task automatic test_push_flush;
    out_ready = 1'b0;
    drive_push(7'd10, 1'b0);
    flush_valid  = 1'b1;
    flush_robidx = 7'd9;
    tick();
    in_valid    = 1'b0;
    flush_valid = 1'b0;
    out_ready   = 1'b1;
    #3;
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL pushflush_occ: got %0d want 1", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushflush_valid: got %0b want 0", out_valid); end
    tick();
    #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL pushflush_dropped: got %0d want 0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushflush_never_out: got %0b want 0", out_valid); end
    tick();
  endtask

  task automatic test_stream;
    int  outs = 0;
    logic exp_ov;
    out_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) drive_push(7'(i % 64), 1'b1);
      else in_valid = 1'b0;
      #3;
`ifdef ALU_WB_BYPASS_EN
      exp_ov = (i < 100);
      if (i < 100) begin
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL stream_bypass_occ[%0d]: got %0d want 0", i, occupancy); end
      end
`else
      exp_ov = (i >= 1 && i <= 100);
`endif
      total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL stream_lag[%0d]: got valid=%0b want %0b", i, out_valid, exp_ov); end
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: got rob=%0d want none", out_robidx);
        end else begin
          exp_t e = exp_q.pop_front();
          outs++;
          if (out_robidx !== e.rob || out_result !== e.res || out_prd !== e.prd ||
              out_need_to_wb !== e.nwb) begin
            bad++;
            $display("FAIL stream_payload[%0d]: got rob=%0d res=%0h want rob=%0d res=%0h",
                     i, out_robidx, out_result, e.rob, e.res);
          end
        end
      end
      tick();
    end
    total++; if (outs != 100) begin bad++; $display("FAIL stream_count: got %0d want 100", outs); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 20; i < 23; i++) begin
      drive_push(7'(i), 1'b0);
      tick();
    end
    #3;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL rstmid_pre_occ: got %0d want 3", occupancy); end
    // Push in the reset cycle must be ignored too.
    drive_push(7'd23, 1'b0);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rstmid_occ: got %0d want 0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      #3;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_reappear[%0d]: got rob=%0d want none", c, out_robidx); end
    end
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_result     = '0;
    in_prd        = '0;
    in_robidx     = '0;
    in_need_to_wb = 1'b0;
    out_ready     = 1'b0;
    flush_valid   = 1'b0;
    flush_robidx  = '0;

    test_reset();
    test_fill_drain();
    test_flush_mid();
    test_wrap_age();
    test_push_flush();
    test_stream();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
